// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ issue requesters.
// Latency: handshake at edge N -> result visible after edge N+1 (S1 issue reg, S2 result reg).
// Backpressure: res_ready low holds S2 (and a full S1) and drops req_ready in the same cycle.
// Optional: define ALU_ARB_PERF_CNT_EN for perf_issued/perf_stall/perf_conflict counters.
module alu_issue_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ALU_OP  = 4,
    parameter int TAG_W   = 6,
    parameter int ID_W    = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ALU_OP-1:0]  req_op,
    input  logic [NUM_REQ*32-1:0]      req_srcA,
    input  logic [NUM_REQ*32-1:0]      req_srcB,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [ALU_OP-1:0]          alu_op,
    output logic [31:0]                alu_srcA,
    output logic [31:0]                alu_srcB,
    input  logic [31:0]                alu_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [31:0]                res_data,
    output logic [ID_W-1:0]            res_id,
    output logic [TAG_W-1:0]           res_tag
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                perf_issued,
    output logic [31:0]                perf_stall,
    output logic [31:0]                perf_conflict
`endif
);

    // S1: issue register feeding the shared ALU
    logic              s1_valid;
    logic [ALU_OP-1:0] s1_op;
    logic [31:0]       s1_srcA;
    logic [31:0]       s1_srcB;
    logic [TAG_W-1:0]  s1_tag;
    logic [ID_W-1:0]   s1_id;

    // S2: result register presented to the consumer
    logic              s2_valid;
    logic [31:0]       s2_data;
    logic [ID_W-1:0]   s2_id;
    logic [TAG_W-1:0]  s2_tag;

    logic [ID_W-1:0]   rr_ptr;

    logic              adv1;
    logic              adv2;
    logic              grant_found;
    logic              grant_fire;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   scan_id;
    logic [ID_W-1:0]   next_ptr;

    logic [ALU_OP-1:0] sel_op;
    logic [31:0]       sel_srcA;
    logic [31:0]       sel_srcB;
    logic [TAG_W-1:0]  sel_tag;

    assign adv2       = !s2_valid || res_ready;
    assign adv1       = !s1_valid || adv2;
    assign grant_fire = grant_found && adv1 && reset_n;

    // Round-robin scan starting at rr_ptr, wrapping at NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_id     = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
            scan_id = (scan_id == ID_W'(NUM_REQ - 1)) ? '0 : scan_id + 1'b1;
        end
    end

    // Pointer moves to the requester after the winner
    always_comb begin
        next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    // One-hot ready to the winner only when the pipeline can accept
    always_comb begin
        req_ready = '0;
        if (grant_fire) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Select the winning requester's payload
    always_comb begin
        sel_op   = '0;
        sel_srcA = '0;
        sel_srcB = '0;
        sel_tag  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_op   = req_op[i*ALU_OP +: ALU_OP];
                sel_srcA = req_srcA[i*32 +: 32];
                sel_srcB = req_srcB[i*32 +: 32];
                sel_tag  = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // S1 load on grant, bubble when advancing with no grant
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_srcA  <= '0;
            s1_srcB  <= '0;
            s1_tag   <= '0;
            s1_id    <= '0;
            rr_ptr   <= '0;
        end else if (adv1) begin
            if (grant_found) begin
                s1_valid <= 1'b1;
                s1_op    <= sel_op;
                s1_srcA  <= sel_srcA;
                s1_srcB  <= sel_srcB;
                s1_tag   <= sel_tag;
                s1_id    <= grant_id;
                rr_ptr   <= next_ptr;
            end else begin
                s1_valid <= 1'b0;
            end
        end
    end

    // S2 captures the ALU result whenever the consumer side can move
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
            s2_tag   <= '0;
        end else if (adv2) begin
            if (s1_valid) begin
                s2_valid <= 1'b1;
                s2_data  <= alu_result;
                s2_id    <= s1_id;
                s2_tag   <= s1_tag;
            end else begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign alu_op    = s1_op;
    assign alu_srcA  = s1_srcA;
    assign alu_srcB  = s1_srcB;
    assign res_valid = s2_valid;
    assign res_data  = s2_data;
    assign res_id    = s2_id;
    assign res_tag   = s2_tag;

`ifdef ALU_ARB_PERF_CNT_EN
    logic is_conflict;
    assign is_conflict = |(req_valid & (req_valid - 1'b1));

    // Free-running wrap-around event counters
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_issued   <= '0;
            perf_stall    <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant_fire) begin
                perf_issued <= perf_issued + 1'b1;
            end
            if ((|req_valid) && !adv1) begin
                perf_stall <= perf_stall + 1'b1;
            end
            if (is_conflict && adv1) begin
                perf_conflict <= perf_conflict + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Testbench for alu_issue_arbiter with NUM_REQ=3 and a queue-based reference model.
// Latency: model tracks in-flight ops as an ordered queue of at most two entries.
// Backpressure: res_ready is driven both in directed patterns and randomly.
module tb_alu_issue_arbiter;

    localparam int N = 3;

    logic            clock;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*4-1:0]  req_op;
    logic [N*32-1:0] req_srcA;
    logic [N*32-1:0] req_srcB;
    logic [N*6-1:0]  req_tag;
    logic [3:0]      alu_op;
    logic [31:0]     alu_srcA;
    logic [31:0]     alu_srcB;
    logic [31:0]     alu_result;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_data;
    logic [1:0]      res_id;
    logic [5:0]      res_tag;
`ifdef ALU_ARB_PERF_CNT_EN
    logic [31:0]     perf_issued;
    logic [31:0]     perf_stall;
    logic [31:0]     perf_conflict;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  id;
        logic [5:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   rr = 0;
    bit   just_issued = 0;
    int   m_issued = 0;
    int   m_stall = 0;
    int   m_conflict = 0;

    alu_issue_arbiter #(.NUM_REQ(N), .ALU_OP(4), .TAG_W(6), .ID_W(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_srcA   (req_srcA),
        .req_srcB   (req_srcB),
        .req_tag    (req_tag),
        .alu_op     (alu_op),
        .alu_srcA   (alu_srcA),
        .alu_srcB   (alu_srcB),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_tag    (res_tag)
`ifdef ALU_ARB_PERF_CNT_EN
        ,
        .perf_issued   (perf_issued),
        .perf_stall    (perf_stall),
        .perf_conflict (perf_conflict)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd6:    return a + b;
            4'd7:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd2:    return ~a;
            default: return 32'd0;
        endcase
    endfunction

    // The shared ALU lives in the bench
    assign alu_result = alu_f(alu_op, alu_srcA, alu_srcB);

    // Pipeline can take a new op unless two are in flight and the consumer stalls
    function automatic bit exp_adv1();
        return (exp_q.size() < 2) || res_ready;
    endfunction

    // Head is visible unless the only in-flight op was accepted at the last edge
    function automatic bit exp_res_valid();
        return (exp_q.size() == 2) || (exp_q.size() == 1 && !just_issued);
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (reset_n && exp_adv1()) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (rr + k) % N;
                if (g == '0 && req_valid[idx]) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [5:0] tag);
        req_op[i*4 +: 4]    = op;
        req_srcA[i*32 +: 32] = a;
        req_srcB[i*32 +: 32] = b;
        req_tag[i*6 +: 6]   = tag;
    endtask

    // Advance one clock edge and update the reference model
    task automatic tick();
        logic [N-1:0] g;
        bit           rv;
        bit           a1;
        int           gi;
        exp_t         e;
        g  = exp_grant();
        rv = exp_res_valid();
        a1 = exp_adv1();
        gi = g[0] ? 0 : (g[1] ? 1 : 2);
        e.data = alu_f(req_op[gi*4 +: 4], req_srcA[gi*32 +: 32], req_srcB[gi*32 +: 32]);
        e.id   = 2'(gi);
        e.tag  = req_tag[gi*6 +: 6];
        @(posedge clock);
        if (!reset_n) begin
            exp_q.delete();
            rr = 0;
            just_issued = 0;
            m_issued = 0;
            m_stall = 0;
            m_conflict = 0;
        end else begin
            if (rv && res_ready) void'(exp_q.pop_front());
            if (g != '0) begin
                exp_q.push_back(e);
                rr = (gi + 1) % N;
            end
            just_issued = (g != '0);
            if (g != '0) m_issued++;
            if ((|req_valid) && !a1) m_stall++;
            if ($countones(req_valid) > 1 && a1) m_conflict++;
        end
        #1;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = '1;
        res_ready = 1'b1;
        req_op = '0; req_srcA = '0; req_srcB = '0; req_tag = '0;
        #1;
        tick();
        tick();
        checks++;
        if (req_ready !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got %b expected 000", req_ready);
        end
        reset_n   = 1'b1;
        req_valid = '0;
        #1;
        checks++;
        if ({res_valid, res_data, res_id, res_tag} !== 41'd0) begin
            errors++; $display("FAIL reset_res: got v=%b d=%h id=%0d tag=%h expected zeros",
                               res_valid, res_data, res_id, res_tag);
        end
        checks++;
        if ({alu_op, alu_srcA, alu_srcB} !== 68'd0) begin
            errors++; $display("FAIL reset_alu: got op=%h a=%h b=%h expected zeros", alu_op, alu_srcA, alu_srcB);
        end
    endtask

    task automatic test_single_op();
        apply_reset();
        res_ready = 1'b1;
        set_req(0, 4'd6, 32'd5, 32'd3, 6'h11);
        req_valid = 3'b001;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL single_grant: got %b expected 001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || alu_op !== 4'd6) begin
            errors++; $display("FAIL single_s1: got v=%b op=%0d expected v=0 op=6", res_valid, alu_op);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd8 || res_id !== 2'd0 || res_tag !== 6'h11) begin
            errors++; $display("FAIL single_res: got v=%b d=%0d id=%0d tag=%h expected 1 8 0 11",
                               res_valid, res_data, res_id, res_tag);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: got %b expected 0", res_valid);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        res_ready = 1'b1;
        set_req(0, 4'd7, 32'd10, 32'd1, 6'd0);
        set_req(1, 4'd7, 32'd10, 32'd1, 6'd1);
        req_valid = 3'b011;
        for (int k = 0; k < 6; k++) begin
            logic [N-1:0] want;
            want = (k % 2 == 0) ? 3'b001 : 3'b010;
            #1;
            checks++;
            if (req_ready !== want) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, want);
            end
            if (k >= 2) begin
                checks++;
                if (res_valid !== 1'b1 || res_data !== 32'd9 || res_id !== 2'(k % 2)) begin
                    errors++; $display("FAIL rr_res[%0d]: got v=%b d=%0d id=%0d expected 1 9 %0d",
                                       k, res_valid, res_data, res_id, k % 2);
                end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int issued;
        int retired;
        issued  = 0;
        retired = 0;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            res_ready = !(k >= 1 && k <= 3);
            req_valid = (issued < 4) ? 3'b001 : 3'b000;
            set_req(0, 4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 6'(issued + 1));
            #1;
            checks++;
            if (req_ready !== exp_grant()) begin
                errors++; $display("FAIL bp_grant[%0d]: got %b expected %b", k, req_ready, exp_grant());
            end
            if (k == 2 || k == 3) begin
                checks++;
                if (req_ready !== 3'b000 || res_valid !== 1'b1 || res_data !== 32'hF000_F000 || res_tag !== 6'd1) begin
                    errors++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h tag=%0d expected 000 1 f000f000 1",
                                       k, req_ready, res_valid, res_data, res_tag);
                end
            end
            if (exp_res_valid()) begin
                checks++;
                if (res_valid !== 1'b1 || res_data !== exp_q[0].data || res_tag !== exp_q[0].tag) begin
                    errors++; $display("FAIL bp_res[%0d]: got v=%b d=%h tag=%0d expected 1 %h %0d",
                                       k, res_valid, res_data, res_tag, exp_q[0].data, exp_q[0].tag);
                end
            end
            if (res_valid && res_ready) retired++;
            if (req_ready[0]) issued++;
            tick();
        end
        checks++;
        if (issued != 4 || retired != 4) begin
            errors++; $display("FAIL bp_count: got issued=%0d retired=%0d expected 4 4", issued, retired);
        end
        res_ready = 1'b1;
    endtask

    task automatic test_wrap();
        apply_reset();
        res_ready = 1'b1;
        set_req(0, 4'd5, 32'h0F, 32'hFF, 6'd3);
        set_req(1, 4'd6, 32'd1, 32'd1, 6'd4);
        set_req(2, 4'd2, 32'd0, 32'd0, 6'd5);
        req_valid = 3'b010;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++; $display("FAIL wrap_first: got %b expected 010", req_ready);
        end
        tick();
        req_valid = 3'b101;
        #1;
        checks++;
        if (req_ready !== 3'b100) begin
            errors++; $display("FAIL wrap_req2: got %b expected 100", req_ready);
        end
        tick();
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL wrap_req0: got %b expected 001", req_ready);
        end
        tick();
        req_valid = 3'b111;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++; $display("FAIL wrap_ptr1: got %b expected 010", req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        res_ready = 1'b1;
        set_req(0, 4'd4, 32'd1, 32'd2, 6'h2A);
        req_valid = 3'b001;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL mid_grant: got %b expected 001", req_ready);
        end
        tick();
        reset_n   = 1'b0;
        req_valid = 3'b011;
        #1;
        checks++;
        if (req_ready !== 3'b000) begin
            errors++; $display("FAIL mid_ready_in_reset: got %b expected 000", req_ready);
        end
        tick();
        reset_n   = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({res_valid, res_data, res_id, res_tag, alu_op, alu_srcA, alu_srcB} !== 109'd0) begin
                errors++; $display("FAIL mid_quiet[%0d]: got v=%b d=%h id=%0d tag=%h op=%h a=%h b=%h expected zeros",
                                   k, res_valid, res_data, res_id, res_tag, alu_op, alu_srcA, alu_srcB);
            end
            tick();
        end
        req_valid = 3'b011;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL mid_ptr0: got %b expected 001", req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [3:0] ops [6];
        ops[0] = 4'd6; ops[1] = 4'd7; ops[2] = 4'd3;
        ops[3] = 4'd4; ops[4] = 4'd5; ops[5] = 4'd2;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom_range(0, 7));
            res_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                set_req(i, ops[$urandom_range(0, 5)], $urandom, $urandom, 6'($urandom));
            end
            #1;
            checks++;
            if (req_ready !== exp_grant()) begin
                errors++; $display("FAIL rand_grant[%0d]: got %b expected %b", c, req_ready, exp_grant());
            end
            checks++;
            if (res_valid !== exp_res_valid()) begin
                errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, res_valid, exp_res_valid());
            end
            if (exp_res_valid()) begin
                checks++;
                if (res_data !== exp_q[0].data || res_id !== exp_q[0].id || res_tag !== exp_q[0].tag) begin
                    errors++; $display("FAIL rand_res[%0d]: got d=%h id=%0d tag=%h expected %h %0d %h",
                                       c, res_data, res_id, res_tag, exp_q[0].data, exp_q[0].id, exp_q[0].tag);
                end
            end
            tick();
        end
`ifdef ALU_ARB_PERF_CNT_EN
        checks++;
        if (perf_issued !== 32'(m_issued) || perf_stall !== 32'(m_stall) || perf_conflict !== 32'(m_conflict)) begin
            errors++; $display("FAIL perf: got %0d %0d %0d expected %0d %0d %0d",
                               perf_issued, perf_stall, perf_conflict, m_issued, m_stall, m_conflict);
        end
`endif
        req_valid = '0;
        res_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
